// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_blink_pkg
//  Purpose  : Definitions shared by the LED blinker and the LED rate detector.
//             Holds the {sw1,sw2} rate codes, the default half-period counts,
//             the detector FSM state type and the bin-match helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package led_blink_pkg;

   // Rate codes in the blinker's {sw1,sw2} encoding
   localparam logic [1:0] RATE_100HZ = 2'b00;
   localparam logic [1:0] RATE_50HZ  = 2'b01;
   localparam logic [1:0] RATE_10HZ  = 2'b10;
   localparam logic [1:0] RATE_1HZ   = 2'b11;

   // Default half-period counts, in clocks
   localparam int unsigned DEF_COUNT_100HZ    = 250_000;
   localparam int unsigned DEF_COUNT_50HZ     = 500_000;
   localparam int unsigned DEF_COUNT_10HZ     = 2_500_000;
   localparam int unsigned DEF_COUNT_1HZ      = 25_000_000;
   localparam int unsigned DEF_TOL_SHIFT      = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;

   // Rate detector FSM states
   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_LOCKED  = 2'd2
   } rate_det_state_t;

   // True when meas lies within centre +/- (centre >> shift).
   // Evaluated in 33 bits so centre + tolerance can never wrap.
   function automatic logic in_rate_bin(input logic [31:0] meas,
                                        input logic [31:0] centre,
                                        input int unsigned shift);
      logic [32:0] tol;
      logic [32:0] lo;
      logic [32:0] hi;
      tol = {1'b0, centre >> shift};
      lo  = {1'b0, centre} - tol;
      hi  = {1'b0, centre} + tol;
      return ({1'b0, meas} >= lo) && ({1'b0, meas} <= hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Generic 1-bit two-flop synchronizer for asynchronous inputs
//             (blink line, switches, enables).
//  Ports    : clock    - destination clock
//             reset_n  - asynchronous active-low reset, flops clear to 0
//             d        - asynchronous input
//             q        - synchronized output (two clocks of latency)
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/led_rate_detector.sv
`default_nettype none
// ============================================================================
//  Module   : led_rate_detector
//  Purpose  : Measures the half-period of an incoming blink signal and
//             classifies it into one of four rates (100/50/10/1 Hz), reporting
//             the locked rate code in the blinker's {sw1,sw2} encoding.
//  Ports    : clock       - single clock, rising edge
//             reset_n     - asynchronous active-low reset
//             blink_in    - asynchronous blinking input
//             rate        - locked rate code (00=100Hz .. 11=1Hz)
//             locked      - rate valid (two consecutive matching measurements)
//             no_signal   - no edge seen for TIMEOUT_CYCLES clocks
//             half_period - last measured half-period, in clocks
//             meas_valid  - one-cycle pulse when half_period updates
//  Revision : 1.0  initial release
// ============================================================================
module led_rate_detector
   import led_blink_pkg::*;
#(
   parameter int unsigned COUNT_100HZ    = DEF_COUNT_100HZ,
   parameter int unsigned COUNT_50HZ     = DEF_COUNT_50HZ,
   parameter int unsigned COUNT_10HZ     = DEF_COUNT_10HZ,
   parameter int unsigned COUNT_1HZ      = DEF_COUNT_1HZ,
   parameter int unsigned TOL_SHIFT      = DEF_TOL_SHIFT,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        blink_in,
   output logic [1:0]  rate,
   output logic        locked,
   output logic        no_signal,
   output logic [31:0] half_period,
   output logic        meas_valid
);

   localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT_CYCLES);

   // -------------------------------------------------------------------------
   // Input synchronization and edge flag
   // -------------------------------------------------------------------------
   logic blink_sync;
   logic blink_prev;
   logic edge_flag;

   sync_2ff u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (blink_in),
      .q       (blink_sync)
   );

   // The edge flag is registered so the counter stage sees a clean one-cycle
   // strobe, two clocks after the input change is first sampled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         blink_prev <= 1'b0;
         edge_flag  <= 1'b0;
      end else begin
         blink_prev <= blink_sync;
         edge_flag  <= blink_sync ^ blink_prev;
      end
   end

   // -------------------------------------------------------------------------
   // Half-period counter and measurement register
   // -------------------------------------------------------------------------
   logic [31:0] cnt;
   logic        armed;        // a timing reference edge has been seen
   logic        timeout_hit;

   // An edge in the same cycle always wins over the timeout.
   assign timeout_hit = (cnt == TIMEOUT_C) && !edge_flag;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         armed       <= 1'b0;
         half_period <= '0;
         meas_valid  <= 1'b0;
         no_signal   <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (edge_flag) begin
            // cnt holds N-1 when edges are N cycles apart, so report cnt+1
            cnt       <= '0;
            armed     <= 1'b1;
            no_signal <= 1'b0;
            if (armed) begin
               half_period <= cnt + 32'd1;
               meas_valid  <= 1'b1;
            end
         end else begin
            if (cnt != TIMEOUT_C) begin
               cnt <= cnt + 32'd1;
            end
            if (timeout_hit) begin
               // Next edge only restarts timing
               no_signal <= 1'b1;
               armed     <= 1'b0;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Classifier: four parallel window comparators on the measurement register,
   // lowest code taking priority should windows ever overlap.
   // -------------------------------------------------------------------------
   logic [3:0] bin_match;
   logic       bin_hit;
   logic [1:0] bin_code;

   assign bin_match[0] = in_rate_bin(half_period, 32'(COUNT_100HZ), TOL_SHIFT);
   assign bin_match[1] = in_rate_bin(half_period, 32'(COUNT_50HZ),  TOL_SHIFT);
   assign bin_match[2] = in_rate_bin(half_period, 32'(COUNT_10HZ),  TOL_SHIFT);
   assign bin_match[3] = in_rate_bin(half_period, 32'(COUNT_1HZ),   TOL_SHIFT);

   always_comb begin
      bin_hit  = 1'b1;
      bin_code = RATE_100HZ;
      if (bin_match[0]) begin
         bin_code = RATE_100HZ;
      end else if (bin_match[1]) begin
         bin_code = RATE_50HZ;
      end else if (bin_match[2]) begin
         bin_code = RATE_10HZ;
      end else if (bin_match[3]) begin
         bin_code = RATE_1HZ;
      end else begin
         bin_hit = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Lock FSM. rate only changes on entry to LOCKED and is held otherwise.
   // -------------------------------------------------------------------------
   rate_det_state_t state;
   logic [1:0]      cand;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_SEARCH;
         cand   <= RATE_100HZ;
         rate   <= RATE_100HZ;
         locked <= 1'b0;
      end else if (timeout_hit) begin
         state  <= ST_SEARCH;
         locked <= 1'b0;
      end else if (meas_valid) begin
         case (state)
            ST_SEARCH: begin
               if (bin_hit) begin
                  state <= ST_CONFIRM;
                  cand  <= bin_code;
               end
            end
            ST_CONFIRM: begin
               if (!bin_hit) begin
                  state <= ST_SEARCH;
               end else if (bin_code == cand) begin
                  state  <= ST_LOCKED;
                  rate   <= cand;
                  locked <= 1'b1;
               end else begin
                  cand <= bin_code;
               end
            end
            ST_LOCKED: begin
               if (!bin_hit) begin
                  state  <= ST_SEARCH;
                  locked <= 1'b0;
               end else if (bin_code != rate) begin
                  state  <= ST_CONFIRM;
                  cand   <= bin_code;
                  locked <= 1'b0;
               end
            end
            default: begin
               state  <= ST_SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_rate_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_rate_detector
//  Purpose  : Directed self-checking bench for led_rate_detector using small
//             bin counts (20/40/200/2000, tolerance shift 2, timeout 4000).
//             Bins: 00=[15,25] 01=[30,50] 10=[150,250] 11=[1500,2500].
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_rate_detector;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        blink_in;
   logic [1:0]  rate;
   logic        locked;
   logic        no_signal;
   logic [31:0] half_period;
   logic        meas_valid;

   int   checks   = 0;
   int   failures = 0;
   logic ns_seen  = 1'b0;

   always #5 clock = ~clock;

   led_rate_detector #(
      .COUNT_100HZ    (20),
      .COUNT_50HZ     (40),
      .COUNT_10HZ     (200),
      .COUNT_1HZ      (2000),
      .TOL_SHIFT      (2),
      .TIMEOUT_CYCLES (4000)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .blink_in    (blink_in),
      .rate        (rate),
      .locked      (locked),
      .no_signal   (no_signal),
      .half_period (half_period),
      .meas_valid  (meas_valid)
   );

   always @(negedge clock) begin
      if (no_signal === 1'b1) ns_seen = 1'b1;
   end

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Toggle blink_in n cycles after the previous toggle, then check the
   // measurement pulse (3 clocks after sampling) and lock state (4 clocks).
   task automatic half(input int n, input string tag, input logic exp_mv,
                       input int exp_hp, input logic exp_lock,
                       input logic [1:0] exp_rate);
      repeat (n - 5) @(posedge clock);
      #1 blink_in = ~blink_in;
      repeat (4) @(posedge clock);
      #1;
      check_val($sformatf("%s_mv", tag), meas_valid, exp_mv);
      if (exp_mv) check_val($sformatf("%s_hp", tag), half_period, exp_hp);
      @(posedge clock);
      #1;
      check_val($sformatf("%s_mv_pulse", tag), meas_valid, 1'b0);
      check_val($sformatf("%s_locked", tag), locked, exp_lock);
      check_val($sformatf("%s_rate", tag), rate, exp_rate);
      check_val($sformatf("%s_nosig", tag), no_signal, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      reset_n  = 1'b0;
      blink_in = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_rate", rate, 2'b00);
      check_val("rst_locked", locked, 1'b0);
      check_val("rst_nosig", no_signal, 1'b0);
      check_val("rst_hp", half_period, 32'd0);
      check_val("rst_mv", meas_valid, 1'b0);
      reset_n = 1'b1;
      repeat (10) @(posedge clock);
      #1;

      // Steady 40: first edge discarded, lock after the third edge
      half(40, "p40_e1", 1'b0, 0,  1'b0, 2'b00);
      half(40, "p40_e2", 1'b1, 40, 1'b0, 2'b00);
      half(40, "p40_e3", 1'b1, 40, 1'b1, 2'b01);
      half(40, "p40_e4", 1'b1, 40, 1'b1, 2'b01);

      // Jitter inside the 50 Hz window keeps lock; 52 is outside every bin
      half(44, "j44a", 1'b1, 44, 1'b1, 2'b01);
      half(36, "j36a", 1'b1, 36, 1'b1, 2'b01);
      half(44, "j44b", 1'b1, 44, 1'b1, 2'b01);
      half(52, "inv52", 1'b1, 52, 1'b0, 2'b01);
      // Back in SEARCH: one good measurement is not enough to lock
      half(40, "rs40a", 1'b1, 40, 1'b0, 2'b01);
      half(40, "rs40b", 1'b1, 40, 1'b1, 2'b01);

      // Rate change 40 -> 200
      half(200, "sw200a", 1'b1, 200, 1'b0, 2'b01);
      half(200, "sw200b", 1'b1, 200, 1'b1, 2'b10);

      // Rate change 200 -> 20
      half(20, "sw20a", 1'b1, 20, 1'b0, 2'b10);
      half(20, "sw20b", 1'b1, 20, 1'b1, 2'b00);

      // Stop toggling: counter cleared 4 clocks after the last toggle,
      // reaches 4000 at +4004 and no_signal follows one clock later
      repeat (3999) @(posedge clock);
      #1;
      check_val("to_before_nosig", no_signal, 1'b0);
      check_val("to_before_locked", locked, 1'b1);
      @(posedge clock);
      #1;
      check_val("to_nosig", no_signal, 1'b1);
      check_val("to_locked", locked, 1'b0);
      check_val("to_rate_held", rate, 2'b00);
      repeat (10) @(posedge clock);
      #1;
      check_val("to_nosig_hold", no_signal, 1'b1);

      // Resume at 2000: first edge only restarts timing
      half(2000, "r2k_e1", 1'b0, 0,    1'b0, 2'b00);
      half(2000, "r2k_e2", 1'b1, 2000, 1'b0, 2'b00);
      half(2000, "r2k_e3", 1'b1, 2000, 1'b1, 2'b11);

      // Edge on the very cycle the counter would reach the timeout
      ns_seen = 1'b0;
      half(4000, "exact_to", 1'b1, 4000, 1'b0, 2'b11);
      check_val("exact_to_ns_seen", ns_seen, 1'b0);
      half(2000, "post_to_a", 1'b1, 2000, 1'b0, 2'b11);
      half(2000, "post_to_b", 1'b1, 2000, 1'b1, 2'b11);

      // Asynchronous reset mid-LOCKED, checked before the next clock edge
      @(posedge clock);
      #3 reset_n = 1'b0;
      blink_in = 1'b0;
      #1;
      check_val("arst_rate", rate, 2'b00);
      check_val("arst_locked", locked, 1'b0);
      check_val("arst_nosig", no_signal, 1'b0);
      check_val("arst_hp", half_period, 32'd0);
      check_val("arst_mv", meas_valid, 1'b0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      half(40, "prst_e1", 1'b0, 0,  1'b0, 2'b00);
      half(40, "prst_e2", 1'b1, 40, 1'b0, 2'b00);
      half(40, "prst_e3", 1'b1, 40, 1'b1, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
